// File: rtl/dma_desc_queue_pkg.sv
// Shared definitions for the DMA descriptor queue.
// Holds the bus width default, the active-low level constants and the sequencer
// state encoding. Also holds a helper that sizes a packed descriptor.
package dma_desc_queue_pkg;

    // Default address width of the system bus.
    localparam int BUS_ADDR_WIDTH = 16;

    // Width of the descriptor transfer-mode field.
    localparam int MODE_W = 2;

    // Levels for the active-low controller strobes (dreq_, eop_).
    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Width of one packed descriptor {saddr, daddr, mode}.
    function automatic int desc_width(input int addr_w);
        return 2 * addr_w + MODE_W;
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with occupancy count.
// full is evaluated before any same-cycle pop, so a push while full is always
// dropped and reported one cycle later on ovf; the stored entries are untouched.
// rdata always shows the head entry, which is meaningful only while !empty.
module dma_desc_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and the overflow pulse. DEPTH is a power of two,
    // so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= push && full;
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor queue and sequencer in front of the DMA controller.
// Descriptors are launched one at a time: IDLE latches the FIFO head onto
// dsaddr/ddaddr/dmode, REQ drives dreq_ low for one cycle, WAIT holds until eop_
// or the watchdog expires (either pops the head), GAP idles before the next launch.
//
// Interface semantics: push is a fire-and-forget strobe with no backpressure
// (a push while full is dropped and flagged on ovf); dreq_ is a one-cycle
// active-low request, and eop_ is honoured only while in WAIT, so a stray eop_
// in IDLE, REQ or GAP neither pops nor pulses. The head entry stays in the FIFO
// for the whole transfer, so count includes the descriptor in flight.
module dma_desc_queue
    import dma_desc_queue_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_saddr,
    input  logic [ADDR_W-1:0] push_daddr,
    input  logic [1:0]        push_mode,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              ovf,
    output logic [ADDR_W-1:0] dsaddr,
    output logic [ADDR_W-1:0] ddaddr,
    output logic [1:0]        dmode,
    output logic              dreq_,
    input  logic              eop_,
    output logic              busy,
    output logic              done,
    output logic              tmo,
    output state_t            dbg_state
);

    localparam int DW   = desc_width(ADDR_W);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;

    state_t          state;
    logic [DW-1:0]   head;
    logic [DW-1:0]   wdata;
    logic            pop;
    logic            eop_seen;
    logic            wd_expired;
    logic [WD_W-1:0] wdog;
    logic [GW-1:0]   gap_cnt;

    assign wdata      = {push_saddr, push_daddr, push_mode};
    assign eop_seen   = (eop_ == ENABLE_N);
    assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));
    // The head leaves the FIFO only when its transfer finishes, either way.
    assign pop        = (state == ST_WAIT) && (eop_seen || wd_expired);
    assign busy       = (state == ST_REQ) || (state == ST_WAIT);
    assign dbg_state  = state;

    dma_desc_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count),
        .ovf   (ovf)
    );

    // Sequencer FSM with its registered outputs, watchdog and gap counter.
    // The watchdog counts cycles since dreq_ went low: it is cleared on entry
    // to REQ, so the REQ cycle itself is the first elapsed cycle. eop_ is
    // tested before expiry so a coincident eop_ reports done, never tmo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            dsaddr  <= '0;
            ddaddr  <= '0;
            dmode   <= '0;
            dreq_   <= DISABLE_N;
            done    <= 1'b0;
            tmo     <= 1'b0;
            wdog    <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            tmo  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        dsaddr <= head[DW-1 -: ADDR_W];
                        ddaddr <= head[MODE_W +: ADDR_W];
                        dmode  <= head[MODE_W-1:0];
                        dreq_  <= ENABLE_N;
                        wdog   <= '0;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    dreq_ <= DISABLE_N;
                    wdog  <= WD_W'(1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eop_seen) begin
                        done    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (wd_expired) begin
                        tmo     <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dma_desc_queue.md
Name: dma_desc_queue

Overview:
- Descriptor queue and sequencer directly upstream of the DMA controller.
- The CPU pushes DMA descriptors (source address, destination address, mode) into a small FIFO.
- The block launches them one at a time on the controller's dsaddr/ddaddr/dmode/dreq_ inputs, then waits for eop_ before launching the next.
- A watchdog aborts any transfer whose eop_ never arrives, so the queue cannot hang.

Parameters:
- ADDR_W, default `BUS_ADDR_WIDTH: width of the source and destination addresses.
- DEPTH, default 4: number of FIFO entries; must be a power of two, at least 2.
- TIMEOUT, default 1024: cycles allowed from dreq_ assertion to eop_ before an abort.
- GAP, default 1: idle cycles with dreq_ high between consecutive transfers; must be at least 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  enqueue strobe, one descriptor per cycle.
- push_saddr  in  ADDR_W  descriptor source address.
- push_daddr  in  ADDR_W  descriptor destination address.
- push_mode  in  2  descriptor transfer mode.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(DEPTH+1)  current occupancy.
- ovf  out  1  one-cycle pulse: push was dropped because the FIFO was full.
- dsaddr  out  ADDR_W  to the DMA controller: source address.
- ddaddr  out  ADDR_W  to the DMA controller: destination address.
- dmode  out  2  to the DMA controller: transfer mode.
- dreq_  out  1  to the DMA controller: transfer request, active-low.
- eop_  in  1  from the DMA controller: end of transfer, active-low.
- busy  out  1  a descriptor is in flight (state is REQ or WAIT).
- done  out  1  one-cycle pulse: transfer completed through eop_.
- tmo  out  1  one-cycle pulse: transfer aborted by the watchdog.

Behaviour:
- Reset values: full=0, empty=1, count=0, ovf=0, dsaddr=0, ddaddr=0, dmode=0, dreq_=1, busy=0, done=0, tmo=0; FIFO pointers 0; state IDLE.
- Reset asserted mid-transfer discards all queued and in-flight descriptors immediately; dreq_ returns to 1 asynchronously.
- FIFO: registered write and read pointers plus count.
  - A push while full is dropped and ovf pulses in the next cycle; FIFO contents are unchanged.
  - full is evaluated before any same-cycle pop, so a push while full is dropped even if a pop happens in the same cycle.
  - A push while not full, in the same cycle as a pop, leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if not empty, latch the head entry into dsaddr/ddaddr/dmode, go to REQ. Latency from the first push into an empty queue to dreq_=0 is 2 cycles.
  - REQ: dreq_=0 for exactly one cycle, watchdog cleared, go to WAIT.
  - WAIT: dreq_=1; the watchdog increments each cycle.
    - eop_=0 sampled: pop the head, pulse done, go to GAP.
    - Watchdog reaches TIMEOUT-1 without eop_: pop the head, pulse tmo, go to GAP.
    - eop_ and the watchdog expiring in the same cycle count as done, not tmo.
  - GAP: hold dreq_=1 for GAP cycles, then go to IDLE.
- dsaddr/ddaddr/dmode stay stable from REQ until the next IDLE load, and hold their last values while idle.
- eop_=0 sampled in IDLE, REQ or GAP is ignored; no pop and no pulse.
- done and tmo are never asserted in the same cycle.
- Only one descriptor is ever in flight.

Decomposition:
- Shared package / define.h additions: state encodings (ST_IDLE, ST_REQ, ST_WAIT, ST_GAP) and the active-low level constants `Enable_/`Disable_ already used for dreq_/eop_.
- Sub-module: dma_desc_fifo, a synchronous FIFO of width 2*ADDR_W+2 with full/empty/count.
- The top level holds the FSM, the watchdog counter and the output registers.

Test Plan:
- Reset, then push one descriptor (saddr=0x0010, daddr=0x0020, mode=2): dreq_=0 exactly 2 cycles after push with dsaddr=0x0010, ddaddr=0x0020, dmode=2. Drive eop_=0 four cycles later: done pulses once, count=0, busy=0.
- Push 4 descriptors back-to-back, then a 5th while full: ovf pulses once, count=4. The four transfers launch in push order, each separated by at least GAP+1 cycles of dreq_=1.
- Push with eop_ never asserted and TIMEOUT=16: tmo pulses 16 cycles after dreq_ low, the entry is popped, and the next queued descriptor launches.
- Drive eop_=0 while IDLE with the queue empty, and during GAP: no done pulse and no pop.
- Assert reset during WAIT with 3 entries queued: dreq_=1 immediately; after release count=0, empty=1, all outputs at reset values.
- With count=2 and a transfer in WAIT, push in the same cycle eop_ is sampled: count stays 2 and done pulses.
